// File: rtl/alu_sched_pkg.sv
// Shared constants and types for the mtm_Alu request scheduler.
package alu_sched_pkg;

  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned N_DATA_TX  = 8;
  localparam int unsigned N_DATA_RX  = 4;

  typedef enum logic {
    FT_DATA = 1'b0,
    FT_CTL  = 1'b1
  } frame_type_e;

  typedef enum logic [1:0] {
    ST_OK        = 2'd0,
    ST_TIMEOUT   = 2'd1,
    ST_FRAME_ERR = 2'd2,
    ST_COUNT_ERR = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    StIdle,
    StTx,
    StWaitRsp,
    StResp
  } state_e;

endpackage

// File: rtl/alu_frame_rx.sv
// Deserializer for one mtm_Alu frame: start 0, type bit, 8 bits MSB first, stop 1.
module alu_frame_rx
  import alu_sched_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        sin_i,
  output logic        busy_o,
  output logic        start_o,
  output logic        done_o,
  output frame_type_e type_o,
  output logic [7:0]  byte_o,
  output logic        stop_err_o
);

  logic       busy_q, busy_d;
  logic [3:0] cnt_q, cnt_d;
  logic [8:0] shift_q, shift_d;
  logic       done_q, done_d;
  logic       stop_err_q, stop_err_d;

  assign start_o = en_i & ~busy_q & ~sin_i;

  always_comb begin
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    done_d     = 1'b0;
    stop_err_d = stop_err_q;
    if (!en_i) begin
      busy_d = 1'b0;
    end else if (!busy_q) begin
      if (!sin_i) begin
        busy_d = 1'b1;
        cnt_d  = '0;
      end
    end else if (cnt_q < 4'(FRAME_BITS - 2)) begin
      shift_d = {shift_q[7:0], sin_i};
      cnt_d   = cnt_q + 4'd1;
    end else begin
      // cnt_q == 9: this is the stop bit
      busy_d     = 1'b0;
      done_d     = 1'b1;
      stop_err_d = ~sin_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      shift_q    <= '0;
      done_q     <= 1'b0;
      stop_err_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      done_q     <= done_d;
      stop_err_q <= stop_err_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign type_o     = frame_type_e'(shift_q[8]);
  assign byte_o     = shift_q[7:0];
  assign stop_err_o = stop_err_q;

endmodule

// File: rtl/alu_req_scheduler.sv
// Round-robin front end sharing one mtm_Alu serial port between N_REQ requesters.
module alu_req_scheduler
  import alu_sched_pkg::*;
#(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [32*N_REQ-1:0]        req_b,
  input  logic [32*N_REQ-1:0]        req_a,
  input  logic [8*N_REQ-1:0]         req_ctl,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [31:0]                rsp_c,
  output logic [7:0]                 rsp_ctl,
  output logic [1:0]                 rsp_status,
  output logic                       alu_sin,
  input  logic                       alu_sout
);

  localparam int unsigned IdW    = $clog2(N_REQ);
  localparam int unsigned TmoW   = $clog2(TIMEOUT + 1);
  localparam logic [IdW:0] NReqW = (IdW + 1)'(N_REQ);
  // RESP is entered exactly TIMEOUT cycles after the final stop bit.
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 2);

  state_e          state_q, state_d;
  logic [IdW-1:0]  ptr_q, ptr_d, id_q, id_d;
  logic [IdW-1:0]  grant_idx, arb_cand;
  logic [IdW:0]    arb_sum;
  logic            grant_found;
  logic [63:0]     data_q, data_d;
  logic [7:0]      ctl_q, ctl_d;
  logic [3:0]      bit_q, bit_d, frame_q, frame_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [31:0]     acc_q, acc_d, rsp_c_q, rsp_c_d;
  logic [3:0]      dcnt_q, dcnt_d;
  logic [7:0]      rsp_ctl_q, rsp_ctl_d;
  status_e         status_q, status_d;
  logic [7:0]      tx_byte;
  logic [2:0]      tx_sel;

  logic        rx_busy, rx_start, rx_done, rx_stop_err;
  frame_type_e rx_type;
  logic [7:0]  rx_byte;

  alu_frame_rx u_rx (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .en_i       (state_q == StWaitRsp),
    .sin_i      (alu_sout),
    .busy_o     (rx_busy),
    .start_o    (rx_start),
    .done_o     (rx_done),
    .type_o     (rx_type),
    .byte_o     (rx_byte),
    .stop_err_o (rx_stop_err)
  );

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    arb_sum     = '0;
    arb_cand    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      arb_sum = {1'b0, ptr_q} + (IdW + 1)'(k);
      if (arb_sum >= NReqW) arb_sum = arb_sum - NReqW;
      arb_cand = arb_sum[IdW-1:0];
      if (!grant_found && req_valid[arb_cand]) begin
        grant_found = 1'b1;
        grant_idx   = arb_cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    data_d    = data_q;
    ctl_d     = ctl_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    tmo_d     = tmo_q;
    acc_d     = acc_q;
    dcnt_d    = dcnt_q;
    rsp_c_d   = rsp_c_q;
    rsp_ctl_d = rsp_ctl_q;
    status_d  = status_q;
    req_ready = '0;
    unique case (state_q)
      StIdle: begin
        if (grant_found && rst_n) begin
          req_ready[grant_idx] = 1'b1;
          id_d    = grant_idx;
          ptr_d   = (grant_idx == IdW'(N_REQ - 1)) ? '0 : grant_idx + IdW'(1);
          data_d  = {req_b[32*grant_idx +: 32], req_a[32*grant_idx +: 32]};
          ctl_d   = req_ctl[8*grant_idx +: 8];
          bit_d   = '0;
          frame_d = '0;
          acc_d   = '0;
          dcnt_d  = '0;
          state_d = StTx;
        end
      end
      StTx: begin
        if (bit_q == 4'(FRAME_BITS - 1)) begin
          bit_d  = '0;
          data_d = data_q << 8;
          if (frame_q == 4'(N_DATA_TX)) begin
            tmo_d   = '0;
            state_d = StWaitRsp;
          end else begin
            frame_d = frame_q + 4'd1;
          end
        end else begin
          bit_d = bit_q + 4'd1;
        end
      end
      StWaitRsp: begin
        tmo_d = (rx_busy || rx_start) ? '0 : tmo_q + TmoW'(1);
        if (rx_done) begin
          if (rx_stop_err) begin
            status_d  = ST_FRAME_ERR;
            rsp_c_d   = '0;
            rsp_ctl_d = '0;
            state_d   = StResp;
          end else if (rx_type == FT_DATA) begin
            acc_d = {acc_q[23:0], rx_byte};
            if (dcnt_q != 4'hf) dcnt_d = dcnt_q + 4'd1;
          end else begin
            rsp_ctl_d = rx_byte;
            rsp_c_d   = (dcnt_q == 4'(N_DATA_RX)) ? acc_q : '0;
            status_d  = (dcnt_q == 4'd0 || dcnt_q == 4'(N_DATA_RX)) ? ST_OK : ST_COUNT_ERR;
            state_d   = StResp;
          end
        end else if (!rx_busy && !rx_start && tmo_q == TmoLast) begin
          status_d  = ST_TIMEOUT;
          rsp_c_d   = '0;
          rsp_ctl_d = '0;
          state_d   = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Serial encoder driven straight from the TX counters.
  always_comb begin
    tx_byte = (frame_q == 4'(N_DATA_TX)) ? ctl_q : data_q[63:56];
    tx_sel  = 3'(4'd9 - bit_q);
    alu_sin = 1'b1;
    if (state_q == StTx) begin
      if (bit_q == 4'd0) begin
        alu_sin = 1'b0;
      end else if (bit_q == 4'd1) begin
        alu_sin = (frame_q == 4'(N_DATA_TX));
      end else if (bit_q <= 4'd9) begin
        alu_sin = tx_byte[tx_sel];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      id_q      <= '0;
      data_q    <= '0;
      ctl_q     <= '0;
      bit_q     <= '0;
      frame_q   <= '0;
      tmo_q     <= '0;
      acc_q     <= '0;
      dcnt_q    <= '0;
      rsp_c_q   <= '0;
      rsp_ctl_q <= '0;
      status_q  <= ST_OK;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      data_q    <= data_d;
      ctl_q     <= ctl_d;
      bit_q     <= bit_d;
      frame_q   <= frame_d;
      tmo_q     <= tmo_d;
      acc_q     <= acc_d;
      dcnt_q    <= dcnt_d;
      rsp_c_q   <= rsp_c_d;
      rsp_ctl_q <= rsp_ctl_d;
      status_q  <= status_d;
    end
  end

  assign rsp_valid  = (state_q == StResp);
  assign rsp_id     = id_q;
  assign rsp_c      = rsp_c_q;
  assign rsp_ctl    = rsp_ctl_q;
  assign rsp_status = status_q;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Directed bench for alu_req_scheduler with a cycle-accurate serial ALU model.
module tb_alu_req_scheduler;

  localparam int unsigned NReq = 2;
  localparam int unsigned Tmo  = 40;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NReq-1:0]   req_valid = '0;
  logic [NReq-1:0]   req_ready;
  logic [32*NReq-1:0] req_b = '0;
  logic [32*NReq-1:0] req_a = '0;
  logic [8*NReq-1:0] req_ctl = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [0:0]        rsp_id;
  logic [31:0]       rsp_c;
  logic [7:0]        rsp_ctl;
  logic [1:0]        rsp_status;
  logic              alu_sin;
  logic              alu_sout = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  alu_req_scheduler #(.N_REQ(NReq), .TIMEOUT(Tmo)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_b      (req_b),
    .req_a      (req_a),
    .req_ctl    (req_ctl),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_c      (rsp_c),
    .rsp_ctl    (rsp_ctl),
    .rsp_status (rsp_status),
    .alu_sin    (alu_sin),
    .alu_sout   (alu_sout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500us");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [98:0] exp_tx(input logic [31:0] b, input logic [31:0] a,
                                         input logic [7:0] ctl);
    logic [63:0] d;
    logic [98:0] v;
    d = {b, a};
    v = '0;
    for (int f = 0; f < 8; f++) begin
      v = {v[87:0], 1'b0, 1'b0, d[63-8*f -: 8], 1'b1};
    end
    v = {v[87:0], 1'b0, 1'b1, ctl, 1'b1};
    return v;
  endfunction

  // Checks the one-cycle grant of requester g and captures the 99 transmitted bits.
  task automatic start_op(input int g, input string tag);
    logic [98:0] cap;
    logic [NReq-1:0] exp_rdy;
    cap = '0;
    exp_rdy = '0;
    exp_rdy[g] = 1'b1;
    #1;
    check({tag, " ready"}, 128'(req_ready), 128'(exp_rdy));
    tick();
    check({tag, " ready pulse"}, 128'(req_ready), 128'(0));
    for (int i = 0; i < 99; i++) begin
      cap = {cap[97:0], alu_sin};
      tick();
    end
    check({tag, " tx"}, 128'(cap),
          128'(exp_tx(req_b[32*g +: 32], req_a[32*g +: 32], req_ctl[8*g +: 8])));
  endtask

  task automatic send_frame(input logic t, input logic [7:0] b, input logic stop);
    logic [10:0] bits;
    bits = {1'b0, t, b, stop};
    for (int i = 10; i >= 0; i--) begin
      alu_sout = bits[i];
      tick();
    end
    alu_sout = 1'b1;
  endtask

  task automatic respond(input logic [31:0] c, input logic [7:0] ctl);
    send_frame(1'b0, c[31:24], 1'b1);
    send_frame(1'b0, c[23:16], 1'b1);
    send_frame(1'b0, c[15:8], 1'b1);
    send_frame(1'b0, c[7:0], 1'b1);
    send_frame(1'b1, ctl, 1'b1);
  endtask

  task automatic finish_rsp(input string tag, input int id, input logic [31:0] c,
                            input logic [7:0] ctl, input logic [1:0] st);
    int n;
    n = 0;
    while (!rsp_valid && n < 200) begin
      tick();
      n++;
    end
    check({tag, " rsp_valid"}, 128'(rsp_valid), 128'(1));
    check({tag, " rsp_id"}, 128'(rsp_id), 128'(id));
    check({tag, " rsp_c"}, 128'(rsp_c), 128'(c));
    check({tag, " rsp_ctl"}, 128'(rsp_ctl), 128'(ctl));
    check({tag, " status"}, 128'(rsp_status), 128'(st));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, " rsp done"}, 128'(rsp_valid), 128'(0));
  endtask

  initial begin
    // Reset state
    tick(); tick(); tick();
    check("reset alu_sin", 128'(alu_sin), 128'(1));
    check("reset req_ready", 128'(req_ready), 128'(0));
    check("reset rsp_valid", 128'(rsp_valid), 128'(0));
    check("reset rsp fields", 128'({rsp_id, rsp_c, rsp_ctl, rsp_status}), 128'(0));
    rst_n = 1'b1;
    tick();

    // Basic op from requester 0
    req_b[31:0] = 32'h0; req_a[31:0] = 32'h1; req_ctl[7:0] = 8'haa;
    req_valid = 2'b01;
    start_op(0, "basic");
    req_valid = '0;
    respond(32'h0000_0001, 8'h20);
    finish_rsp("basic", 0, 32'h1, 8'h20, 2'd0);

    // Ctl-only reply, requester 1 (moves pointer back to 0)
    req_b[63:32] = 32'hdead_beef; req_a[63:32] = 32'h0bad_f00d; req_ctl[15:8] = 8'hc3;
    req_valid = 2'b10;
    start_op(1, "ctlonly");
    req_valid = '0;
    send_frame(1'b1, 8'hc9, 1'b1);
    finish_rsp("ctlonly", 1, 32'h0, 8'hc9, 2'd0);

    // Round robin with both valid continuously
    req_b[31:0] = 32'h1122_3344; req_a[31:0] = 32'h5566_7788; req_ctl[7:0] = 8'h5a;
    req_valid = 2'b11;
    for (int r = 0; r < 4; r++) begin
      int g;
      g = r % 2;
      start_op(g, $sformatf("rr%0d", r));
      respond(g == 0 ? 32'hcafe_0001 : 32'h1234_5678, g == 0 ? 8'h20 : 8'h21);
      if (r == 0) begin
        // Hold the response: no new grant while it is outstanding
        for (int w = 0; w < 4 && !rsp_valid; w++) tick();
        tick(); tick();
        check("rr hold rsp_valid", 128'(rsp_valid), 128'(1));
        check("rr hold no grant", 128'(req_ready), 128'(0));
        check("rr hold rsp_c", 128'(rsp_c), 128'(32'hcafe_0001));
      end
      finish_rsp($sformatf("rr%0d", r), g, g == 0 ? 32'hcafe_0001 : 32'h1234_5678,
                 g == 0 ? 8'h20 : 8'h21, 2'd0);
    end
    req_valid = '0;

    // Data-count error: two data frames then ctl
    req_valid = 2'b01;
    start_op(0, "cnterr");
    req_valid = '0;
    send_frame(1'b0, 8'h12, 1'b1);
    send_frame(1'b0, 8'h34, 1'b1);
    send_frame(1'b1, 8'h77, 1'b1);
    finish_rsp("cnterr", 0, 32'h0, 8'h77, 2'd3);

    // Framing error: stop bit 0 in the first frame
    req_valid = 2'b01;
    start_op(0, "frmerr");
    req_valid = '0;
    send_frame(1'b0, 8'h12, 1'b0);
    finish_rsp("frmerr", 0, 32'h0, 8'h0, 2'd2);

    // Silent ALU: timeout exactly Tmo cycles after the final stop bit
    req_valid = 2'b01;
    start_op(0, "tmo");
    req_valid = '0;
    for (int i = 0; i < int'(Tmo) - 2; i++) tick();
    check("tmo early", 128'(rsp_valid), 128'(0));
    tick();
    finish_rsp("tmo", 0, 32'h0, 8'h0, 2'd1);

    // Reset at bit 50 of TX; pointer was left at 1
    req_valid = 2'b01;
    #1;
    check("rst grant", 128'(req_ready), 128'(1));
    tick();
    req_valid = '0;
    for (int i = 0; i < 50; i++) tick();
    rst_n = 1'b0;
    req_valid = 2'b11;
    tick();
    check("rst alu_sin", 128'(alu_sin), 128'(1));
    check("rst rsp_valid", 128'(rsp_valid), 128'(0));
    check("rst req_ready", 128'(req_ready), 128'(0));
    rst_n = 1'b1;
    start_op(0, "after rst");
    req_valid = '0;
    respond(32'h0a0b_0c0d, 8'h22);
    finish_rsp("after rst", 0, 32'h0a0b_0c0d, 8'h22, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_req_scheduler.md
Name: alu_req_scheduler

Overview:
- Shares one mtm_Alu serial port between N_REQ parallel requesters.
- Arbitrates round-robin and accepts one operation at a time (B, A, CTL).
- Serializes the operation onto the ALU `sin` line, deserializes the answer from `sout`, and returns it to the granted requester.
- Sits between the mtm_Alu instance and the system-side command sources.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- TIMEOUT, 1023, clock cycles to wait for the response control frame after the last transmitted stop bit.

Ports:
- clk  input  1  posedge clock
- rst_n  input  1  synchronous reset, active low
- req_valid  input  N_REQ  per-requester operation valid
- req_ready  output  N_REQ  per-requester accept strobe (one-hot or zero)
- req_b  input  32*N_REQ  operand B, requester i at [32i+31:32i]
- req_a  input  32*N_REQ  operand A, same packing
- req_ctl  input  8*N_REQ  control byte (opcode/CRC), sent unmodified
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response accepted
- rsp_id  output  $clog2(N_REQ)  index of the requester owning the response
- rsp_c  output  32  result from data frames, first byte received in [31:24]
- rsp_ctl  output  8  received control byte
- rsp_status  output  2  0=ok, 1=timeout, 2=framing error, 3=data-count error
- alu_sin  output  1  to mtm_Alu sin
- alu_sout  input  1  from mtm_Alu sout

Behaviour:
- Reset (rst_n=0 at posedge):
  - alu_sin=1; req_ready=0; rsp_valid=0; rsp_id/rsp_c/rsp_ctl/rsp_status=0.
  - RR pointer=0; FSM=IDLE.
  - Reset mid-frame aborts immediately: the line returns high next cycle and no response is produced.
- Frame format, one bit per clk:
  - start 0, type bit (0=data, 1=ctl), 8 payload bits MSB first, stop 1: 11 cycles per frame.
  - Frames are back-to-back, no extra idle bits.
- Transmit order: B[31:24], B[23:16], B[15:8], B[7:0], A[31:24] .. A[7:0] (8 data frames), then the ctl frame carrying req_ctl. Total 99 bit cycles.
- FSM states: IDLE, TX, WAIT_RSP, RESP.
- IDLE:
  - If any req_valid, grant the first valid index at or after the RR pointer, wrapping.
  - Assert that req_ready bit for exactly 1 cycle; latch operands and grant id.
  - RR pointer = grant+1 mod N_REQ. Go to TX.
  - If no req_valid, stay in IDLE.
- Transmit latency: handshake at cycle T; start bit of the first frame on alu_sin at T+1; final stop bit at T+99.
- TX: a bit counter (0..10) and frame counter (0..8) advance each cycle. After the final stop bit, go to WAIT_RSP and clear the timeout counter.
- Receiver:
  - Active in WAIT_RSP; samples alu_sout every cycle and detects a start bit as 0 while idle-high.
  - Captures type + 8 bits, then checks the stop bit.
  - Data frame: shift the byte into rsp_c (left shift by 8) and increment the data count.
  - Ctl frame: latch rsp_ctl and complete the response.
  - Status priority: stop bit 0 → framing error (2), complete immediately. Otherwise data count not in {0,4} at the ctl frame → data-count error (3). Otherwise ok (0).
  - rsp_c is valid only when data count=4; otherwise rsp_c=0.
- Timeout:
  - The counter runs while no frame is in progress and resets on each start bit.
  - Reaching TIMEOUT sets status 1, rsp_ctl=0, rsp_c=0.
- RESP:
  - rsp_valid=1 with stable outputs until rsp_valid&rsp_ready; then go to IDLE.
  - No new grant is issued while in TX, WAIT_RSP or RESP (one outstanding operation).
  - rsp_ready high in the first RESP cycle completes in that cycle; the next grant can occur the cycle after.
- req_valid dropping before grant: no grant, no error.
- Input/arrival order does not affect arbitration; only the RR pointer does.

Decomposition:
- Package alu_sched_pkg:
  - FRAME_BITS=11, N_DATA_TX=8, N_DATA_RX=4.
  - Frame type enum {FT_DATA, FT_CTL}.
  - Status enum {ST_OK, ST_TIMEOUT, ST_FRAME_ERR, ST_COUNT_ERR}.
  - FSM state enum.
- Sub-module alu_frame_rx:
  - Serial-to-byte deserializer with frame-done, type and stop-error outputs.
  - Instantiated once.
- Arbiter and transmitter stay in the top module.

Test Plan:
- Req0 valid, B=0, A=1, ctl=8'haa:
  - req_ready[0] pulses 1 cycle.
  - alu_sin shows 7 data frames of 0x00, then 0x01, then ctl 0xaa (type bit 1), 99 cycles total.
  - Model returns data frames 00,00,00,01 then ctl 0x20 → rsp_id=0, rsp_c=32'h1, rsp_ctl=8'h20, status 0.
- Req0 and req1 valid continuously:
  - Grants alternate 0,1,0,1.
  - The second grant occurs only after the first rsp handshake.
  - rsp_id matches the grant order.
- Model sends only a ctl frame 8'hc9 → rsp_c=0, rsp_ctl=8'hc9, status 0.
- Error responses:
  - Model sends 2 data frames then ctl → status 3.
  - Model sends stop bit 0 in the first frame → status 2.
- Model stays silent: exactly TIMEOUT cycles after the last stop bit, rsp_valid=1, status 1.
- Reset asserted at bit 50 of TX:
  - Next cycle alu_sin=1 and rsp_valid=0.
  - After release, the RR pointer=0 and req0 is granted first.
